btn_event_gen: RTL and testbench



---
 rtl/btn_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/btn_event_gen.sv | 164 ++++++++++++++++
 tb/tb_btn_event_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types for the minesweeper button front end: event codes, button indices, arbiter priority.
package btn_pkg;

  localparam int unsigned BTN_COUNT = 6;

  typedef enum logic [2:0] {
    EvNone   = 3'd0,
    EvRight  = 3'd1,
    EvLeft   = 3'd2,
    EvUp     = 3'd3,
    EvDown   = 3'd4,
    EvChoose = 3'd5,
    EvClear  = 3'd6
  } ev_code_t;

  typedef logic [2:0] btn_idx_t;

  // Direction buttons occupy indices 0..3 so the repeat timers can index them directly.
  localparam btn_idx_t BtnRight  = 3'd0;
  localparam btn_idx_t BtnLeft   = 3'd1;
  localparam btn_idx_t BtnUp     = 3'd2;
  localparam btn_idx_t BtnDown   = 3'd3;
  localparam btn_idx_t BtnChoose = 3'd4;
  localparam btn_idx_t BtnClear  = 3'd5;

  // Highest priority first.
  localparam btn_idx_t BtnPrio [BTN_COUNT] = '{
    BtnClear, BtnChoose, BtnRight, BtnLeft, BtnUp, BtnDown
  };

  function automatic ev_code_t btn_code(btn_idx_t idx);
    return ev_code_t'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, counter debounce, registered press pulse on the debounced rise.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic sync1_q, sync2_q;
  logic lvl_q, lvl_d;
  logic press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The level flips on the DEB_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CntMax) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign press_o = press_q;

endmodule

// File: rtl/btn_event_gen.sv
// Button front end: debounced presses -> pending bits -> priority arbiter -> event FIFO.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat on the four direction buttons.
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 12500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] buttomx,
  input  logic [1:0] buttomy,
  input  logic       choose,
  input  logic       clear,
  output logic       ev_valid,
  output logic [2:0] ev_code,
  input  logic       ev_ready,
  output logic       ev_merged
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [BTN_COUNT-1:0] btn_raw, btn_lvl, btn_press, btn_set;

  always_comb begin
    btn_raw            = '0;
    btn_raw[BtnRight]  = (buttomx == 2'b01);
    btn_raw[BtnLeft]   = (buttomx == 2'b10);
    btn_raw[BtnUp]     = (buttomy == 2'b10);
    btn_raw[BtnDown]   = (buttomy == 2'b01);
    btn_raw[BtnChoose] = choose;
    btn_raw[BtnClear]  = clear;
  end

  for (genvar g = 0; g < BTN_COUNT; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .btn_i  (btn_raw[g]),
      .level_o(btn_lvl[g]),
      .press_o(btn_press[g])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelayLim  = RepW'(REP_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLim = RepW'(REP_PERIOD - 1);

  logic [RepW-1:0] rep_cnt_q [4];
  logic [RepW-1:0] rep_cnt_d [4];
  logic [3:0] rep_phase_q, rep_phase_d, rep_q, rep_d;

  // Phase 0 waits REP_DELAY after the press, phase 1 repeats every REP_PERIOD.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rep_cnt_d[i]   = '0;
      rep_phase_d[i] = 1'b0;
      rep_d[i]       = 1'b0;
      if (btn_lvl[i]) begin
        if (rep_cnt_q[i] == (rep_phase_q[i] ? RepPeriodLim : RepDelayLim)) begin
          rep_d[i]       = 1'b1;
          rep_phase_d[i] = 1'b1;
        end else begin
          rep_cnt_d[i]   = rep_cnt_q[i] + 1'b1;
          rep_phase_d[i] = rep_phase_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= '0;
      rep_phase_q <= '0;
      rep_q       <= '0;
    end else begin
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= rep_cnt_d[i];
      rep_phase_q <= rep_phase_d;
      rep_q       <= rep_d;
    end
  end

  assign btn_set = btn_press | {2'b00, rep_q};
`else
  logic unused_cfg;
  assign unused_cfg = ^{btn_lvl, REP_DELAY, REP_PERIOD};
  assign btn_set    = btn_press;
`endif

  logic [BTN_COUNT-1:0] pend_q, pend_d;
  ev_code_t mem_q [FIFO_DEPTH];
  ev_code_t mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic merged_q, merged_d;
  logic empty, full, pop, wr_en, any_pend;
  btn_idx_t sel;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = ev_valid & ev_ready;

  // Scan lowest to highest priority so the last hit wins.
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    for (int i = int'(BTN_COUNT) - 1; i >= 0; i--) begin
      if (pend_q[BtnPrio[i]]) begin
        sel      = BtnPrio[i];
        any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d   = pend_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = any_pend & (~full | pop);
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en) begin
      if (sel == BtnClear) begin
        mem_d[0] = EvClear;
        rd_ptr_d = '0;
        wr_ptr_d = (AW + 1)'(1);
        pend_d   = '0;
      end else begin
        mem_d[wr_ptr_q[AW-1:0]] = btn_code(sel);
        wr_ptr_d    = wr_ptr_q + 1'b1;
        pend_d[sel] = 1'b0;
      end
    end
    // A bit being granted or flushed this cycle is free, so a press onto it is a new event.
    merged_d = |(btn_set & pend_d);
    pend_d   = pend_d | btn_set;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      merged_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= EvNone;
    end else begin
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      merged_q <= merged_d;
      mem_q    <= mem_d;
    end
  end

  assign ev_valid  = ~empty;
  assign ev_code   = ev_valid ? mem_q[rd_ptr_q[AW-1:0]] : EvNone;
  assign ev_merged = merged_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen; expected codes and timings are hand-computed.
module tb_btn_event_gen;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] buttomx, buttomy;
  logic       choose, clear;
  logic       ev_valid, ev_ready, ev_merged;
  logic [2:0] ev_code;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_merge = 0;
  logic [2:0] log_c[$];
  int         log_t[$];

  btn_event_gen #(
    .DEB_CYCLES(4),
    .FIFO_DEPTH(4),
    .REP_DELAY (20),
    .REP_PERIOD(8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .buttomx  (buttomx),
    .buttomy  (buttomy),
    .choose   (choose),
    .clear    (clear),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ready (ev_ready),
    .ev_merged(ev_merged)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Accepted events are logged on the falling edge, just before the popping edge.
  always @(negedge CLK) begin
    if (RST_N && ev_valid && ev_ready) begin
      log_c.push_back(ev_code);
      log_t.push_back(cyc);
    end
    if (ev_merged) n_merge++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int log_at(input int i);
    if (i < log_c.size()) return int'(log_c[i]);
    return 99;
  endfunction

  function automatic int time_at(input int i);
    if (i < log_t.size()) return log_t[i];
    return -1000;
  endfunction

  task automatic clear_log();
    log_c.delete();
    log_t.delete();
  endtask

  task automatic drive(input int btn, input logic on);
    case (btn)
      0: buttomx = on ? 2'b01 : 2'b00;
      1: buttomx = on ? 2'b10 : 2'b00;
      2: buttomy = on ? 2'b10 : 2'b00;
      3: buttomy = on ? 2'b01 : 2'b00;
      4: choose  = on;
      default: clear = on;
    endcase
  endtask

  task automatic press(input int btn);
    drive(btn, 1'b1);
    step(8);
    drive(btn, 1'b0);
    step(8);
  endtask

  int c0;

  initial begin
    RST_N    = 1'b0;
    buttomx  = 2'b00;
    buttomy  = 2'b00;
    choose   = 1'b0;
    clear    = 1'b0;
    ev_ready = 1'b1;
    step(3);
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_code", ev_code, 0);
    check_eq("rst_merged", ev_merged, 0);
    RST_N = 1'b1;
    step(4);

    // Single RIGHT press: raw sampled at edge k, valid at k+7.
    clear_log();
    buttomx = 2'b01;
    step(7);
    check_eq("lat_early_valid", ev_valid, 0);
    step(1);
    check_eq("lat_valid", ev_valid, 1);
    check_eq("lat_code", ev_code, 1);
    buttomx = 2'b00;
    step(12);
    check_eq("right_count", log_c.size(), 1);
    check_eq("right_code", log_at(0), 1);

    // Three-cycle glitch on choose is filtered.
    clear_log();
    choose = 1'b1;
    step(3);
    choose = 1'b0;
    step(12);
    check_eq("glitch_count", log_c.size(), 0);
    check_eq("glitch_valid", ev_valid, 0);

    // Simultaneous UP and CHOOSE: CHOOSE wins, UP next cycle.
    clear_log();
    buttomy = 2'b10;
    choose  = 1'b1;
    step(12);
    buttomy = 2'b00;
    choose  = 1'b0;
    step(12);
    check_eq("simul_count", log_c.size(), 2);
    check_eq("simul_first", log_at(0), 5);
    check_eq("simul_second", log_at(1), 3);
    check_eq("simul_gap", time_at(1) - time_at(0), 1);

    // Backpressure: fill the FIFO, park DOWN in pending, then merge a second DOWN.
    clear_log();
    ev_ready = 1'b0;
    press(0);
    press(1);
    press(2);
    press(3);
    check_eq("full_valid", ev_valid, 1);
    check_eq("full_head", ev_code, 1);
    n_merge = 0;
    press(3);
    check_eq("pend_no_merge", n_merge, 0);
    press(3);
    check_eq("merge_pulse", n_merge, 1);
    ev_ready = 1'b1;
    step(10);
    check_eq("drain_count", log_c.size(), 5);
    check_eq("drain_0", log_at(0), 1);
    check_eq("drain_1", log_at(1), 2);
    check_eq("drain_2", log_at(2), 3);
    check_eq("drain_3", log_at(3), 4);
    check_eq("drain_4", log_at(4), 4);
    check_eq("drain_b2b", time_at(4) - time_at(0), 4);

    // CLEAR flushes three queued events.
    clear_log();
    ev_ready = 1'b0;
    press(0);
    press(1);
    press(2);
    check_eq("preclr_head", ev_code, 1);
    press(5);
    check_eq("clr_head", ev_code, 6);
    ev_ready = 1'b1;
    step(5);
    check_eq("clr_count", log_c.size(), 1);
    check_eq("clr_code", log_at(0), 6);
    check_eq("clr_empty", ev_valid, 0);

    // Reset with two events queued and LEFT held through release.
    clear_log();
    ev_ready = 1'b0;
    press(0);
    press(2);
    check_eq("prerst_valid", ev_valid, 1);
    buttomx = 2'b10;
    step(3);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("async_rst_valid", ev_valid, 0);
    check_eq("async_rst_code", ev_code, 0);
    check_eq("async_rst_merged", ev_merged, 0);
    step(3);
    RST_N = 1'b1;
    clear_log();
    ev_ready = 1'b1;
    step(7);
    check_eq("relrst_early", ev_valid, 0);
    step(1);
    check_eq("relrst_valid", ev_valid, 1);
    check_eq("relrst_code", ev_code, 2);
    buttomx = 2'b00;
    step(12);
    check_eq("relrst_count", log_c.size(), 1);

    // Hold DOWN for 60 cycles.
    clear_log();
    c0 = cyc;
    buttomy = 2'b01;
    step(60);
    buttomy = 2'b00;
    step(20);
    check_eq("hold_first_code", log_at(0), 4);
    check_eq("hold_first_time", time_at(0) - c0, 8);
`ifdef BTN_AUTOREPEAT_EN
    check_eq("rep_enough", (log_c.size() >= 4) ? 1 : 0, 1);
    check_eq("rep_code1", log_at(1), 4);
    check_eq("rep_code3", log_at(3), 4);
    check_eq("rep_gap1", time_at(1) - time_at(0), 20);
    check_eq("rep_gap2", time_at(2) - time_at(1), 8);
    check_eq("rep_gap3", time_at(3) - time_at(2), 8);
`else
    check_eq("hold_count", log_c.size(), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
